// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of a shared 4-digit hex display with a minimum hold time.
module display_arbiter #(
    parameter logic [23:0] HOLD_CYCLES = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] value0,
    input  logic [15:0] value1,
    input  logic [15:0] value2,
    output logic [2:0]  grant,
    output logic [15:0] display_value,
    output logic        start_signal,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t      state, state_n;
    logic [1:0]  ptr, ptr_n, c1, c2, win;
    logic [23:0] cnt, cnt_n;
    logic [2:0]  grant_n;
    logic [15:0] disp_n, win_val, own_val;
    logic        start_n, started, started_n;

    // ptr doubles as the current owner while in HOLD
    assign c1      = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    assign c2      = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
    assign win     = req[c1] ? c1 : req[c2] ? c2 : ptr;
    assign win_val = (win == 2'd0) ? value0 : (win == 2'd1) ? value1 : value2;
    assign own_val = (ptr == 2'd0) ? value0 : (ptr == 2'd1) ? value1 : value2;
    assign busy    = state != IDLE;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        grant_n   = grant;
        disp_n    = display_value;
        start_n   = 1'b0;
        started_n = started;
        case (state)
            IDLE: state_n = |req ? LOAD : IDLE;
            LOAD: begin
                state_n = |req ? HOLD : IDLE;
                if (|req) begin
                    grant_n   = 3'b001 << win;
                    disp_n    = win_val;
                    ptr_n     = win;
                    cnt_n     = HOLD_CYCLES - 24'd1;
                    start_n   = !started;
                    started_n = 1'b1;
                end
            end
            HOLD: begin
                disp_n  = req[ptr] ? own_val : display_value;
                cnt_n   = (cnt == 24'd0) ? cnt : cnt - 24'd1;
                grant_n = (cnt == 24'd0) ? 3'b000 : grant;
                state_n = (cnt != 24'd0) ? HOLD : |req ? LOAD : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= 2'd2;
            cnt           <= 24'd0;
            grant         <= 3'b000;
            display_value <= 16'h0000;
            start_signal  <= 1'b0;
            started       <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            cnt           <= cnt_n;
            grant         <= grant_n;
            display_value <= disp_n;
            start_signal  <= start_n;
            started       <= started_n;
        end
    end
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: vector table plus hand sequences, expected outputs queued and checked after each edge.
module tb_display_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [15:0] value0 = 16'h1234;
    logic [15:0] value1 = 16'h5555;
    logic [15:0] value2 = 16'h7777;
    logic [2:0]  grant;
    logic [15:0] display_value;
    logic        start_signal, busy;

    typedef struct {
        logic        rst;
        logic [2:0]  rq;
        logic [15:0] v0;
        logic [2:0]  g;
        logic [15:0] d;
        logic        s;
        logic        b;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   row = 0;

    display_arbiter #(.HOLD_CYCLES(24'd4)) dut (
        .clk(clk), .reset(reset), .req(req),
        .value0(value0), .value1(value1), .value2(value2),
        .grant(grant), .display_value(display_value),
        .start_signal(start_signal), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic [2:0] rq, logic [15:0] v0,
                                logic [2:0] g, logic [15:0] d, logic s, logic b);
        vec_t v;
        v.rst = rst; v.rq = rq; v.v0 = v0; v.g = g; v.d = d; v.s = s; v.b = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // drive one row before the edge, queue its expectation, compare just after the edge
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset  = v.rst;
        req    = v.rq;
        value0 = v.v0;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("grant", {13'd0, grant}, {13'd0, e.g});
        chk("display_value", display_value, e.d);
        chk("start_signal", {15'd0, start_signal}, {15'd0, e.s});
        chk("busy", {15'd0, busy}, {15'd0, e.b});
        row++;
    endtask

    initial begin
        // single source grant, hold and release
        tbl.push_back(mk(1, 3'b000, 16'h1234, 3'b000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 3'b001, 16'h1234, 3'b000, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 3'b001, 16'h1234, 3'b001, 16'h1234, 1, 1));
        tbl.push_back(mk(0, 3'b001, 16'h1234, 3'b001, 16'h1234, 0, 1));
        tbl.push_back(mk(0, 3'b000, 16'h1234, 3'b001, 16'h1234, 0, 1));
        tbl.push_back(mk(0, 3'b000, 16'h1234, 3'b001, 16'h1234, 0, 1));
        tbl.push_back(mk(0, 3'b000, 16'h1234, 3'b000, 16'h1234, 0, 0));
        tbl.push_back(mk(0, 3'b000, 16'h1234, 3'b000, 16'h1234, 0, 0));
        // all three requesting: rotation 0,1,2,0 with one-cycle gaps
        tbl.push_back(mk(1, 3'b111, 16'h1234, 3'b000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b000, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b001, 16'h1234, 1, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b001, 16'h1234, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b001, 16'h1234, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b001, 16'h1234, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b000, 16'h1234, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b010, 16'h5555, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b010, 16'h5555, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b010, 16'h5555, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b010, 16'h5555, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b000, 16'h5555, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b100, 16'h7777, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b100, 16'h7777, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b100, 16'h7777, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b100, 16'h7777, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b000, 16'h7777, 0, 1));
        tbl.push_back(mk(0, 3'b111, 16'h1234, 3'b001, 16'h1234, 0, 1));
        // owner updates value mid-hold, then drops req: display freezes, grant stays
        tbl.push_back(mk(1, 3'b000, 16'h1234, 3'b000, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 3'b001, 16'h1234, 3'b000, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 3'b001, 16'h1234, 3'b001, 16'h1234, 1, 1));
        tbl.push_back(mk(0, 3'b001, 16'hABCD, 3'b001, 16'hABCD, 0, 1));
        tbl.push_back(mk(0, 3'b000, 16'h1111, 3'b001, 16'hABCD, 0, 1));
        tbl.push_back(mk(0, 3'b000, 16'h1111, 3'b001, 16'hABCD, 0, 1));
        tbl.push_back(mk(0, 3'b000, 16'h1111, 3'b000, 16'hABCD, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // request vanishes before LOAD: back to IDLE, no grant, start still pending
        step(mk(1, 3'b000, 16'h1234, 3'b000, 16'h0000, 0, 0));
        step(mk(0, 3'b010, 16'h1234, 3'b000, 16'h0000, 0, 1));
        step(mk(0, 3'b000, 16'h1234, 3'b000, 16'h0000, 0, 0));
        step(mk(0, 3'b000, 16'h1234, 3'b000, 16'h0000, 0, 0));
        step(mk(0, 3'b010, 16'h1234, 3'b000, 16'h0000, 0, 1));
        step(mk(0, 3'b010, 16'h1234, 3'b010, 16'h5555, 1, 1));
        step(mk(0, 3'b000, 16'h1234, 3'b010, 16'h5555, 0, 1));
        // reset in the second HOLD cycle, then source 2 wins with a fresh start pulse
        step(mk(1, 3'b000, 16'h1234, 3'b000, 16'h0000, 0, 0));
        step(mk(0, 3'b100, 16'h1234, 3'b000, 16'h0000, 0, 1));
        step(mk(0, 3'b100, 16'h1234, 3'b100, 16'h7777, 1, 1));
        step(mk(0, 3'b000, 16'h1234, 3'b100, 16'h7777, 0, 1));

        // late request during HOLD neither preempts nor stretches the hold
        step(mk(1, 3'b000, 16'h1234, 3'b000, 16'h0000, 0, 0));
        step(mk(0, 3'b001, 16'h1234, 3'b000, 16'h0000, 0, 1));
        step(mk(0, 3'b001, 16'h1234, 3'b001, 16'h1234, 1, 1));
        step(mk(0, 3'b101, 16'h1234, 3'b001, 16'h1234, 0, 1));
        step(mk(0, 3'b101, 16'h1234, 3'b001, 16'h1234, 0, 1));
        step(mk(0, 3'b101, 16'h1234, 3'b001, 16'h1234, 0, 1));
        step(mk(0, 3'b101, 16'h1234, 3'b000, 16'h1234, 0, 1));
        step(mk(0, 3'b101, 16'h1234, 3'b100, 16'h7777, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
